// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: load/store size codes, write-back
// source select codes, FSM state encoding and byte-enable patterns.
package mem_access_unit_pkg;

   // FUNC3 codes for loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // write-back value select
   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;

   // byte enables
   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_LO_HALF = 4'b0011;
   localparam logic [3:0] BE_HI_HALF = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } mau_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } access_size_t;

   // Unknown FUNC3 values fall back to a full-word access.
   function automatic access_size_t access_size(input logic [2:0] func3);
      access_size_t sz;
      case (func3)
         F3_B, F3_BU: sz = SZ_BYTE;
         F3_H, F3_HU: sz = SZ_HALF;
         default:     sz = SZ_WORD;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
//
// Handshake: the master raises exactly one of D_MEM_READ / D_MEM_WRITE together
// with address, write data and byte enables, and holds all of them stable
// until a rising edge at which D_MEM_BUSYWAIT is 0; that edge completes the
// transfer (read data is sampled on it) and the request drops after it. The
// master may also withdraw a request (wait-limit abort or reset) without a
// completing edge.
interface mem_access_unit_if;
   logic        D_MEM_READ;
   logic        D_MEM_WRITE;
   logic [31:0] D_MEM_ADDR;
   logic [31:0] D_MEM_WRITEDATA;
   logic [3:0]  D_MEM_BYTE_EN;
   logic [31:0] D_MEM_READDATA;
   logic        D_MEM_BUSYWAIT;

   modport master (
      output D_MEM_READ, D_MEM_WRITE, D_MEM_ADDR, D_MEM_WRITEDATA, D_MEM_BYTE_EN,
      input  D_MEM_READDATA, D_MEM_BUSYWAIT
   );

   modport slave (
      input  D_MEM_READ, D_MEM_WRITE, D_MEM_ADDR, D_MEM_WRITEDATA, D_MEM_BYTE_EN,
      output D_MEM_READDATA, D_MEM_BUSYWAIT
   );
endinterface

// File: rtl/mem_access_unit_load_store_align.sv
// Combinational lane logic: store byte enables and data replication, load
// byte/half extraction with sign or zero extension, and misalignment detect.
// Misaligned halfword/word accesses are truncated to natural alignment here;
// whether they are issued at all is decided by the caller.
module load_store_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  func3,
   input  logic [31:0] store_data,
   input  logic [31:0] read_data,
   output logic [3:0]  byte_en,
   output logic [31:0] store_word,
   output logic [31:0] load_value,
   output logic        misaligned
);

   access_size_t size;
   logic [1:0]   a;
   logic [7:0]   sel_byte;
   logic [15:0]  sel_half;
   logic         is_signed;

   // decode size, steer store lanes and extract/extend load data
   always_comb begin
      size       = access_size(func3);
      is_signed  = ~func3[2];
      a          = addr_lo;
      misaligned = 1'b0;
      byte_en    = BE_NONE;
      store_word = store_data;
      load_value = read_data;
      sel_byte   = 8'h00;
      sel_half   = 16'h0000;
      case (size)
         SZ_BYTE: begin
            byte_en    = BE_BYTE0 << a;
            store_word = {4{store_data[7:0]}};
            sel_byte   = read_data[{a, 3'b000} +: 8];
            load_value = is_signed ? {{24{sel_byte[7]}}, sel_byte} : {24'h000000, sel_byte};
         end
         SZ_HALF: begin
            misaligned = addr_lo[0];
            a          = {addr_lo[1], 1'b0};
            byte_en    = a[1] ? BE_HI_HALF : BE_LO_HALF;
            store_word = {2{store_data[15:0]}};
            sel_half   = a[1] ? read_data[31:16] : read_data[15:0];
            load_value = is_signed ? {{16{sel_half[15]}}, sel_half} : {16'h0000, sel_half};
         end
         default: begin
            misaligned = |addr_lo;
            a          = 2'b00;
            byte_en    = BE_WORD;
            store_word = store_data;
            load_value = read_data;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the RV32IM pipeline with the MEM/WB register. Runs a
// request/busywait handshake against the data memory, stalls the front of the
// pipeline while an access is outstanding and aborts after WAIT_LIMIT access
// cycles. Optional build macro: MISALIGN_TRAP_EN (misaligned accesses are not
// issued and raise MISALIGN_EXC instead of being truncated).
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int WAIT_LIMIT = 255
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [31:0]              ALU_RES_EXMEM,
   input  logic [31:0]              DATA_2_EXMEM,
   input  logic [31:0]              PC_EXMEM,
   input  logic [2:0]               FUNC3_EXMEM,
   input  logic                     MEM_READ_EN_EXMEM,
   input  logic                     MEM_WRITE_EN_EXMEM,
   input  logic                     REG_WRITE_EN_EXMEM,
   input  logic [1:0]               WB_VALUE_SEL_EXMEM,
   input  logic [4:0]               REG_WRITE_ADDR_EXMEM,
   mem_access_unit_if.master        dmem,
   output logic [31:0]              ALU_RES_MEM,
   output logic                     STALL,
   output logic [31:0]              WRITE_DATA_WB,
   output logic [4:0]               REG_WRITE_ADDR_WB,
   output logic                     REG_WRITE_EN_WB,
   output logic                     BUS_ERR,
   output logic                     MISALIGN_EXC,
   output mau_state_t               STATE_DBG
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);

   mau_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        stall_int;
   logic        complete;
   logic        abort;
   logic        mem_op;
   logic        trap;
   logic        issue;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] lane_load;
   logic        misaligned;
   logic [31:0] load_q;
   logic [31:0] wb_value;
   logic        wb_en_d;

   load_store_align u_align (
      .addr_lo    (ALU_RES_EXMEM[1:0]),
      .func3      (FUNC3_EXMEM),
      .store_data (DATA_2_EXMEM),
      .read_data  (dmem.D_MEM_READDATA),
      .byte_en    (lane_be),
      .store_word (lane_wdata),
      .load_value (lane_load),
      .misaligned (misaligned)
   );

   assign mem_op = MEM_READ_EN_EXMEM | MEM_WRITE_EN_EXMEM;

`ifdef MISALIGN_TRAP_EN
   assign trap = mem_op & misaligned;
`else
   logic unused_misaligned;
   assign unused_misaligned = misaligned;
   assign trap = 1'b0;
`endif

   assign issue       = mem_op & ~trap;
   assign ALU_RES_MEM = ALU_RES_EXMEM;
   assign STALL       = RESET & stall_int;
   assign STATE_DBG   = state_q;

   // state register and wait counter
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state, stall, and access completion/abort decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_int = 1'b0;
      complete  = 1'b0;
      abort     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (issue) begin
               stall_int = 1'b1;
               state_d   = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            stall_int = 1'b1;
            cnt_d     = cnt_q + CW'(1);
            if (!dmem.D_MEM_BUSYWAIT) begin
               complete = 1'b1;
               state_d  = ST_DONE;
            end else if (cnt_q == CW'(WAIT_LIMIT - 1)) begin
               abort   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // memory request registers: launched from IDLE, dropped when ACCESS ends
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         dmem.D_MEM_READ      <= 1'b0;
         dmem.D_MEM_WRITE     <= 1'b0;
         dmem.D_MEM_ADDR      <= 32'h0;
         dmem.D_MEM_WRITEDATA <= 32'h0;
         dmem.D_MEM_BYTE_EN   <= BE_NONE;
      end else if (state_q == ST_IDLE && issue) begin
         // a store wins when both enables are set
         dmem.D_MEM_WRITE     <= MEM_WRITE_EN_EXMEM;
         dmem.D_MEM_READ      <= MEM_READ_EN_EXMEM & ~MEM_WRITE_EN_EXMEM;
         dmem.D_MEM_ADDR      <= {ALU_RES_EXMEM[31:2], 2'b00};
         dmem.D_MEM_WRITEDATA <= lane_wdata;
         dmem.D_MEM_BYTE_EN   <= MEM_WRITE_EN_EXMEM ? lane_be : BE_NONE;
      end else if (complete || abort) begin
         dmem.D_MEM_READ    <= 1'b0;
         dmem.D_MEM_WRITE   <= 1'b0;
         dmem.D_MEM_BYTE_EN <= BE_NONE;
      end
   end

   // capture formatted load data on completion; flag a wait-limit abort
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         load_q  <= 32'h0;
         BUS_ERR <= 1'b0;
      end else begin
         BUS_ERR <= abort;
         if (complete) begin
            load_q <= lane_load;
         end
      end
   end

   // write-back source select and write enable for the MEM/WB register
   always_comb begin
      wb_value = 32'h0;
      case (WB_VALUE_SEL_EXMEM)
         WB_SEL_ALU: wb_value = ALU_RES_EXMEM;
         WB_SEL_MEM: wb_value = load_q;
         WB_SEL_PC4: wb_value = PC_EXMEM + 32'd4;
         default:    wb_value = 32'h0;
      endcase
      wb_en_d = 1'b0;
      case (state_q)
         // plain ALU/JAL instructions pass straight through; any mem op here is
         // either issuing (bubble) or trapped (suppressed)
         ST_IDLE: wb_en_d = REG_WRITE_EN_EXMEM & ~mem_op;
         ST_DONE: wb_en_d = REG_WRITE_EN_EXMEM & ~BUS_ERR
                            & ~(MEM_READ_EN_EXMEM & MEM_WRITE_EN_EXMEM);
         default: wb_en_d = 1'b0;
      endcase
   end

   // MEM/WB pipeline register, loaded on every edge
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         WRITE_DATA_WB     <= 32'h0;
         REG_WRITE_ADDR_WB <= 5'd0;
         REG_WRITE_EN_WB   <= 1'b0;
      end else begin
         WRITE_DATA_WB     <= wb_value;
         REG_WRITE_ADDR_WB <= REG_WRITE_ADDR_EXMEM;
         REG_WRITE_EN_WB   <= wb_en_d;
      end
   end

`ifdef MISALIGN_TRAP_EN
   // one-cycle exception pulse for a suppressed misaligned access
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         MISALIGN_EXC <= 1'b0;
      end else begin
         MISALIGN_EXC <= (state_q == ST_IDLE) & trap;
      end
   end
`else
   assign MISALIGN_EXC = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with an op-level reference model,
// a write-back scoreboard and a small busywait memory model.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int WL = 255;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] ALU_RES_EXMEM, DATA_2_EXMEM, PC_EXMEM;
   logic [2:0]  FUNC3_EXMEM;
   logic        MEM_READ_EN_EXMEM, MEM_WRITE_EN_EXMEM, REG_WRITE_EN_EXMEM;
   logic [1:0]  WB_VALUE_SEL_EXMEM;
   logic [4:0]  REG_WRITE_ADDR_EXMEM;
   logic [31:0] ALU_RES_MEM;
   logic        STALL;
   logic [31:0] WRITE_DATA_WB;
   logic [4:0]  REG_WRITE_ADDR_WB;
   logic        REG_WRITE_EN_WB;
   logic        BUS_ERR, MISALIGN_EXC;
   mau_state_t  STATE_DBG;

   mem_access_unit_if dmem ();

   mem_access_unit #(.WAIT_LIMIT(WL)) dut (
      .CLK                  (CLK),
      .RESET                (RESET),
      .ALU_RES_EXMEM        (ALU_RES_EXMEM),
      .DATA_2_EXMEM         (DATA_2_EXMEM),
      .PC_EXMEM             (PC_EXMEM),
      .FUNC3_EXMEM          (FUNC3_EXMEM),
      .MEM_READ_EN_EXMEM    (MEM_READ_EN_EXMEM),
      .MEM_WRITE_EN_EXMEM   (MEM_WRITE_EN_EXMEM),
      .REG_WRITE_EN_EXMEM   (REG_WRITE_EN_EXMEM),
      .WB_VALUE_SEL_EXMEM   (WB_VALUE_SEL_EXMEM),
      .REG_WRITE_ADDR_EXMEM (REG_WRITE_ADDR_EXMEM),
      .dmem                 (dmem),
      .ALU_RES_MEM          (ALU_RES_MEM),
      .STALL                (STALL),
      .WRITE_DATA_WB        (WRITE_DATA_WB),
      .REG_WRITE_ADDR_WB    (REG_WRITE_ADDR_WB),
      .REG_WRITE_EN_WB      (REG_WRITE_EN_WB),
      .BUS_ERR              (BUS_ERR),
      .MISALIGN_EXC         (MISALIGN_EXC),
      .STATE_DBG            (STATE_DBG)
   );

   // clock / watchdog
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // memory model: busy for mem_lat cycles of an outstanding request
   int          mem_lat = 0;
   int          req_cyc = 0;
   logic [31:0] mem_rdata = 32'h0;

   always @(posedge CLK) begin
      if (dmem.D_MEM_READ || dmem.D_MEM_WRITE) req_cyc <= req_cyc + 1;
      else req_cyc <= 0;
   end
   assign dmem.D_MEM_BUSYWAIT = (dmem.D_MEM_READ || dmem.D_MEM_WRITE) && (req_cyc < mem_lat);
   assign dmem.D_MEM_READDATA = mem_rdata;

   // scoreboard state
   int          total = 0;
   int          bad = 0;
   logic [36:0] exp_q[$];
   logic [36:0] wb_e;
   int          bus_err_seen = 0, bus_err_exp = 0;
   int          mis_seen = 0, mis_exp = 0;

   // last request observed on the bus
   bit          last_seen;
   logic        last_rd, last_wr;
   logic [31:0] last_addr, last_wd;
   logic [3:0]  last_be;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // compare process: every write-back must match the next expected entry
   always @(negedge CLK) begin
      if (REG_WRITE_EN_WB === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h want no write-back",
                     REG_WRITE_ADDR_WB, WRITE_DATA_WB);
         end else begin
            wb_e = exp_q.pop_front();
            check("wb_data", WRITE_DATA_WB, wb_e[31:0]);
            check("wb_rd", {27'h0, REG_WRITE_ADDR_WB}, {27'h0, wb_e[36:32]});
         end
      end
      if (BUS_ERR === 1'b1) bus_err_seen++;
      if (MISALIGN_EXC === 1'b1) mis_seen++;
   end

   task automatic drive(input logic [31:0] alu, rs2, pc, input logic [2:0] f3,
                        input logic rd_en, wr_en, rw_en, input logic [1:0] sel,
                        input logic [4:0] rd);
      ALU_RES_EXMEM        = alu;
      DATA_2_EXMEM         = rs2;
      PC_EXMEM             = pc;
      FUNC3_EXMEM          = f3;
      MEM_READ_EN_EXMEM    = rd_en;
      MEM_WRITE_EN_EXMEM   = wr_en;
      REG_WRITE_EN_EXMEM   = rw_en;
      WB_VALUE_SEL_EXMEM   = sel;
      REG_WRITE_ADDR_EXMEM = rd;
   endtask

   // Drive one EX/MEM instruction at a negedge, hold it while stalled, check it
   // against the model, and return at the negedge after its MEM/WB load.
   task automatic run_op(input string nm, input logic [31:0] alu, rs2, pc,
                         input logic [2:0] f3, input logic rd_en, wr_en, rw_en,
                         input logic [1:0] sel, input logic [4:0] rd,
                         input logic [31:0] rdata, input int lat, output int n);
      int          size, a, a_eff, exp_stall;
      bit          mis, trap, issue, aborted, exp_en;
      logic [31:0] raw, ld, exp_wb, exp_wd;
      logic [3:0]  exp_be;
      case (f3)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         default:        size = 4;
      endcase
      a   = int'(alu[1:0]);
      mis = (size == 2 && (a % 2) == 1) || (size == 4 && a != 0);
`ifdef MISALIGN_TRAP_EN
      trap = (rd_en || wr_en) && mis;
`else
      trap = 1'b0;
`endif
      issue   = (rd_en || wr_en) && !trap;
      aborted = issue && (lat >= WL);
      a_eff   = (size == 4) ? 0 : (size == 2) ? (a / 2) * 2 : a;
      raw     = rdata >> (8 * a_eff);
      if (size == 1) begin
         ld = raw & 32'hFF;
         if (!f3[2] && ld[7]) ld = ld | 32'hFFFFFF00;
      end else if (size == 2) begin
         ld = raw & 32'hFFFF;
         if (!f3[2] && ld[15]) ld = ld | 32'hFFFF0000;
      end else begin
         ld = rdata;
      end
      case (sel)
         2'b00:   exp_wb = alu;
         2'b01:   exp_wb = ld;
         2'b10:   exp_wb = pc + 32'd4;
         default: exp_wb = 32'h0;
      endcase
      exp_en    = issue ? (rw_en && !(rd_en && wr_en) && !aborted) : (!(rd_en || wr_en) && rw_en);
      exp_stall = issue ? (aborted ? 1 + WL : lat + 2) : 0;
      exp_be    = (size == 1) ? 4'(1 << a) : (size == 2) ? 4'(3 << a_eff) : 4'hF;
      exp_wd    = (size == 1) ? {24'h0, rs2[7:0]} * 32'h01010101 :
                  (size == 2) ? {16'h0, rs2[15:0]} * 32'h00010001 : rs2;
      if (trap) mis_exp++;
      if (aborted) bus_err_exp++;
      if (exp_en) exp_q.push_back({rd, exp_wb});

      mem_lat   = lat;
      mem_rdata = rdata;
      drive(alu, rs2, pc, f3, rd_en, wr_en, rw_en, sel, rd);
      last_seen = 1'b0;
      n = 0;
      #1;
      while (STALL === 1'b1 && n < 400) begin
         n++;
         @(negedge CLK);
         #1;
         if (!last_seen && (dmem.D_MEM_READ || dmem.D_MEM_WRITE)) begin
            last_seen = 1'b1;
            last_rd   = dmem.D_MEM_READ;
            last_wr   = dmem.D_MEM_WRITE;
            last_addr = dmem.D_MEM_ADDR;
            last_wd   = dmem.D_MEM_WRITEDATA;
            last_be   = dmem.D_MEM_BYTE_EN;
         end
      end
      check({nm, "_stall"}, n, exp_stall);
      if (issue) begin
         check({nm, "_addr"}, last_addr, alu & 32'hFFFFFFFC);
         check({nm, "_rdreq"}, {31'h0, last_rd}, {31'h0, !wr_en});
         check({nm, "_wrreq"}, {31'h0, last_wr}, {31'h0, wr_en});
         if (wr_en) begin
            check({nm, "_be"}, {28'h0, last_be}, {28'h0, exp_be});
            check({nm, "_wdata"}, last_wd, exp_wd);
         end
      end else begin
         check({nm, "_noreq"}, {31'h0, last_seen}, 32'h0);
      end
      @(negedge CLK);
      check({nm, "_reqdrop"}, {31'h0, dmem.D_MEM_READ | dmem.D_MEM_WRITE}, 32'h0);
   endtask

   int n;

   initial begin
      RESET = 1'b0;
      drive(32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
      repeat (2) @(negedge CLK);
      #1;
      check("rst_stall", {31'h0, STALL}, 32'h0);
      check("rst_wb_en", {31'h0, REG_WRITE_EN_WB}, 32'h0);
      check("rst_wb_data", WRITE_DATA_WB, 32'h0);
      check("rst_wb_rd", {27'h0, REG_WRITE_ADDR_WB}, 32'h0);
      check("rst_rd_req", {31'h0, dmem.D_MEM_READ}, 32'h0);
      check("rst_be", {28'h0, dmem.D_MEM_BYTE_EN}, 32'h0);
      check("rst_state", {30'h0, STATE_DBG}, {30'h0, ST_IDLE});
      check("rst_pulses", {30'h0, BUS_ERR, MISALIGN_EXC}, 32'h0);
      @(negedge CLK);
      RESET = 1'b1;

      // ADD, no memory op: zero latency pass-through
      run_op("add", 32'h00000010, 32'h0, 32'h0, 3'b000, 0, 0, 1, 2'b00, 5'd5, 32'h0, 0, n);
      check("add_wb_lit", WRITE_DATA_WB, 32'h00000010);
      check("add_en_lit", {31'h0, REG_WRITE_EN_WB}, 32'h1);
      check("alu_fwd", ALU_RES_MEM, 32'h00000010);
      run_op("add2", 32'h12345678, 32'h0, 32'h0, 3'b000, 0, 0, 1, 2'b00, 5'd7, 32'h0, 0, n);

      // LB 0x103 with 2 busy cycles
      run_op("lb", 32'h00000103, 32'h0, 32'h0, 3'b000, 1, 0, 1, 2'b01, 5'd6, 32'h80FF1234, 2, n);
      check("lb_stall_lit", n, 32'd4);
      check("lb_addr_lit", last_addr, 32'h00000100);
      check("lb_wb_lit", WRITE_DATA_WB, 32'hFFFFFF80);

      // SH 0x202
      run_op("sh", 32'h00000202, 32'h0000ABCD, 32'h0, 3'b001, 0, 1, 0, 2'b00, 5'd0, 32'h0, 1, n);
      check("sh_be_lit", {28'h0, last_be}, 32'h0000000C);
      check("sh_wd_lit", last_wd, 32'hABCDABCD);
      check("sh_en_lit", {31'h0, REG_WRITE_EN_WB}, 32'h0);

      run_op("sb", 32'h00000101, 32'h12345678, 32'h0, 3'b000, 0, 1, 0, 2'b00, 5'd0, 32'h0, 0, n);
      run_op("sw", 32'h00000300, 32'hCAFEF00D, 32'h0, 3'b010, 0, 1, 0, 2'b00, 5'd0, 32'h0, 0, n);
      run_op("lbu", 32'h00000102, 32'h0, 32'h0, 3'b100, 1, 0, 1, 2'b01, 5'd8, 32'h80FF1234, 1, n);
      run_op("lh", 32'h00000102, 32'h0, 32'h0, 3'b001, 1, 0, 1, 2'b01, 5'd9, 32'h80FF1234, 0, n);
      check("lh_wb_lit", WRITE_DATA_WB, 32'hFFFF80FF);
      run_op("lhu", 32'h00000100, 32'h0, 32'h0, 3'b101, 1, 0, 1, 2'b01, 5'd10, 32'h80FF9234, 3, n);
      run_op("lw", 32'h00000104, 32'h0, 32'h0, 3'b010, 1, 0, 1, 2'b01, 5'd11, 32'hDEADBEEF, 0, n);
      run_op("ld011", 32'h00000108, 32'h0, 32'h0, 3'b011, 1, 0, 1, 2'b01, 5'd12, 32'h01020304, 1, n);
      run_op("rdwr", 32'h0000010C, 32'h55667788, 32'h0, 3'b010, 1, 1, 1, 2'b01, 5'd13, 32'h11111111, 0, n);
      run_op("sel11", 32'h0000FFFF, 32'h0, 32'h0, 3'b000, 0, 0, 1, 2'b11, 5'd14, 32'h0, 0, n);

      // wait limit boundary: last allowed cycle completes, one more aborts
      run_op("lw_edge", 32'h00000200, 32'h0, 32'h0, 3'b010, 1, 0, 1, 2'b01, 5'd15, 32'h0BADF00D, WL - 1, n);
      run_op("lw_abort", 32'h00000204, 32'h0, 32'h0, 3'b010, 1, 0, 1, 2'b01, 5'd16, 32'h12121212, 1000, n);
      check("abort_stall_lit", n, 32'd256);

      // misaligned word / half
      run_op("lw_mis", 32'h00000102, 32'h0, 32'h0, 3'b010, 1, 0, 1, 2'b01, 5'd17, 32'hA5A5C3C3, 0, n);
`ifdef MISALIGN_TRAP_EN
      check("mis_pulse_lit", {31'h0, MISALIGN_EXC}, 32'h1);
`else
      check("mis_addr_lit", last_addr, 32'h00000100);
`endif
      run_op("lh_mis", 32'h00000103, 32'h0, 32'h0, 3'b001, 1, 0, 1, 2'b01, 5'd18, 32'h7F001234, 1, n);
      run_op("sh_mis", 32'h00000201, 32'h00001357, 32'h0, 3'b001, 0, 1, 0, 2'b00, 5'd0, 32'h0, 0, n);

      // reset in the middle of an access
      mem_lat = 1000;
      drive(32'h00000400, 32'h0, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 2'b01, 5'd19);
      repeat (3) @(negedge CLK);
      #1;
      check("mid_rd_req", {31'h0, dmem.D_MEM_READ}, 32'h1);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("mid_rst_rd", {31'h0, dmem.D_MEM_READ}, 32'h0);
      check("mid_rst_stall", {31'h0, STALL}, 32'h0);
      drive(32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      run_op("jal", 32'h0, 32'h0, 32'hFFFFFFFC, 3'b000, 0, 0, 1, 2'b10, 5'd1, 32'h0, 0, n);
      check("jal_wb_lit", WRITE_DATA_WB, 32'h00000000);

      // drain and final tallies
      drive(32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
      repeat (3) @(negedge CLK);
      check("exp_q_empty", exp_q.size(), 32'd0);
      check("bus_err_pulses", bus_err_seen, bus_err_exp);
      check("misalign_pulses", mis_seen, mis_exp);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM stage of the RV32IM 5-stage pipeline, including the MEM/WB pipeline register.
- Consumes the EX/MEM register (ALU result, store data, control) and runs a handshake FSM against the data memory, which raises busywait.
- Performs byte-lane steering for stores and alignment/sign-extension for loads.
- Produces write-back data, the MEM forwarding value and a pipeline stall.

Parameters:
- WAIT_LIMIT, 255, max cycles in ACCESS before bus-error abort; counter width is clog2(WAIT_LIMIT+1).

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- ALU_RES_EXMEM  in  32  effective address / ALU result
- DATA_2_EXMEM  in  32  store data (rs2, already forwarded)
- PC_EXMEM  in  32  instruction PC
- FUNC3_EXMEM  in  3  load/store size and sign
- MEM_READ_EN_EXMEM  in  1  load
- MEM_WRITE_EN_EXMEM  in  1  store
- REG_WRITE_EN_EXMEM  in  1  register write enable
- WB_VALUE_SEL_EXMEM  in  2  00 ALU, 01 MEM, 10 PC+4
- REG_WRITE_ADDR_EXMEM  in  5  rd
- D_MEM_READDATA  in  32  memory read word
- D_MEM_BUSYWAIT  in  1  memory busy
- D_MEM_READ  out  1  read request (registered)
- D_MEM_WRITE  out  1  write request (registered)
- D_MEM_ADDR  out  32  word address, bits[1:0]=0
- D_MEM_WRITEDATA  out  32  lane-replicated store data
- D_MEM_BYTE_EN  out  4  byte enables
- ALU_RES_MEM  out  32  combinational pass-through of ALU_RES_EXMEM, for EX forwarding
- STALL  out  1  freeze PC/IF/ID/EX/EX-MEM
- WRITE_DATA_WB  out  32  MEM/WB write-back value
- REG_WRITE_ADDR_WB  out  5  MEM/WB rd
- REG_WRITE_EN_WB  out  1  MEM/WB write enable
- BUS_ERR  out  1  one-cycle pulse on wait-limit abort
- MISALIGN_EXC  out  1  one-cycle pulse, misaligned access

Behaviour:
- Reset (async, RESET=0):
  - state=IDLE, wait counter=0.
  - D_MEM_READ/WRITE=0, D_MEM_BYTE_EN=0.
  - All *_WB outputs=0, BUS_ERR=0, MISALIGN_EXC=0.
  - Reset mid-ACCESS drops the request immediately; no write-back.
- FSM states and transitions:
  - IDLE:
    - If a mem op is present (MEM_READ_EN_EXMEM or MEM_WRITE_EN_EXMEM), it is not suppressed as misaligned, and STALL=1: drive request regs next edge and go to ACCESS.
    - If no mem op: MEM/WB loads every edge; zero added latency.
  - ACCESS:
    - D_MEM_READ or D_MEM_WRITE held high; counter increments each cycle.
    - At the first edge with D_MEM_BUSYWAIT=0: capture the formatted load data, drop the request, go to DONE.
    - If the counter reaches WAIT_LIMIT with busywait still 1: drop the request, pulse BUS_ERR, go to DONE with REG_WRITE_EN_WB forced to 0.
  - DONE:
    - STALL=0; MEM/WB loads at this edge; go to IDLE.
- STALL:
  - Combinational; =1 in IDLE with an issuing mem op, and =1 throughout ACCESS; 0 otherwise.
  - While STALL=1, MEM/WB loads a bubble (REG_WRITE_EN_WB=0) so the write-back happens exactly once.
- Minimum mem-op occupancy is 3 cycles (IDLE, 1 ACCESS, DONE); each extra busywait cycle adds 1.
- Simultaneous MEM_READ_EN and MEM_WRITE_EN: write takes priority; no register write-back of load data.
- Store lanes, by FUNC3 and address bits a=addr[1:0]:
  - SB(000): BYTE_EN = 1<<a; data is rs2[7:0] replicated x4.
  - SH(001): BYTE_EN = 0011 or 1100 by a[1]; data is rs2[15:0] replicated x2.
  - SW(010): BYTE_EN = 1111.
- Load formatting of D_MEM_READDATA:
  - LB(000) and LBU(100): select byte a, then sign- or zero-extend.
  - LH(001) and LHU(101): select half a[1], then sign- or zero-extend.
  - LW(010): full word.
  - Any other FUNC3: treated as LW.
- WRITE_DATA_WB mux:
  - WB_VALUE_SEL=00: ALU result.
  - 01: formatted load.
  - 10: PC_EXMEM+4, wrapping modulo 2^32.
  - 11: 0.
- Misaligned: halfword with a[0]=1, or word with a≠00.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A misaligned op is not issued; the FSM stays in IDLE.
  - STALL=0; MISALIGN_EXC pulses for 1 cycle.
  - MEM/WB loads with REG_WRITE_EN_WB=0.
- MISALIGN_TRAP_EN undefined:
  - MISALIGN_EXC is tied 0.
  - Low address bits are truncated to the natural alignment (half: a[0]=0; word: a=00) and the access issues normally.

Decomposition:
- Shared package holds:
  - FUNC3 load/store codes.
  - WB_VALUE_SEL codes (ALU/MEM/PC4).
  - FSM state encoding (IDLE/ACCESS/DONE).
  - Byte-enable constants.
- One combinational sub-module, load_store_align: store lane steering/byte enables, load extraction/extension, misalign detect.

Test Plan:
- ADD result 0x00000010, WB_SEL=00, no mem op -> STALL=0; next edge WRITE_DATA_WB=0x00000010, REG_WRITE_EN_WB=1.
- LB at addr 0x103, READDATA=0x80FF_1234, busywait high for 2 cycles -> D_MEM_ADDR=0x100, STALL high for 4 cycles, WRITE_DATA_WB=0xFFFFFF80 written once.
- SH at addr 0x202, rs2=0x0000ABCD -> BYTE_EN=1100, WRITEDATA=0xABCDABCD, REG_WRITE_EN_WB=0.
- Busywait held high -> after WAIT_LIMIT ACCESS cycles: BUS_ERR pulse, request dropped, no write-back.
- RESET low during ACCESS -> D_MEM_READ=0 and STALL=0 immediately; after release, a JAL with PC=0xFFFFFFFC gives WRITE_DATA_WB=0x00000000.
- LW at 0x102 with MISALIGN_TRAP_EN -> MISALIGN_EXC pulse, no D_MEM_READ; without it -> D_MEM_ADDR=0x100, normal load.
